// File: rtl/mac_issue_queue.sv
// mac_issue_queue: issue stage in front of the 16x16 / dual 8x8 MAC.
// Buffers {instruction, multiplier, multiplicand} packets in a valid/ready
// FIFO, presents the head packet to the MAC, drives the MAC stall and
// tracks the MAC pipeline latency so downstream logic knows when the MAC
// result/protect outputs belong to an issued instruction.
// Optional feature macro: MAC_ISSUE_BYPASS_EN (empty-queue 0-cycle bypass).
module mac_issue_queue #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              ext_hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_instruction,
    input  logic [15:0]       in_multiplier,
    input  logic [15:0]       in_multiplicand,
    output logic [2:0]        mac_instruction,
    output logic [15:0]       mac_multiplier,
    output logic [15:0]       mac_multiplicand,
    output logic              mac_stall,
    output logic              res_valid,
    output logic [2:0]        res_op,
    output logic [ADDR_W:0]   fifo_count
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

    // Packet storage (data only, never reset)
    logic [2:0]          mem_instr [DEPTH];
    logic signed [15:0]  mem_mplr  [DEPTH];
    logic signed [15:0]  mem_mcnd  [DEPTH];

    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W:0]     count;

    // Last packet handed to the MAC; shown whenever the MAC is stalled
    logic [2:0]          last_instr;
    logic signed [15:0]  last_mplr;
    logic signed [15:0]  last_mcnd;

    // Latency tracker, stage 0 loaded on issue, last stage drives res_*
    logic                trk_vld [MAC_LAT];
    logic [2:0]          trk_op  [MAC_LAT];

    logic                empty;
    logic                bypass;
    logic                issue;
    logic                push;
    logic                pop;
    logic [2:0]          issue_instr;
    logic signed [15:0]  issue_mplr;
    logic signed [15:0]  issue_mcnd;

    assign empty = (count == '0);

`ifdef MAC_ISSUE_BYPASS_EN
    // An empty queue forwards the incoming packet straight to the MAC
    assign bypass = empty & in_valid & ~ext_hold & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign mac_stall  = (empty & ~bypass) | ext_hold | flush;
    assign issue      = ~mac_stall;
    assign pop        = issue & ~bypass;
    assign in_ready   = (count != CNT_FULL);
    assign push       = in_valid & in_ready & ~flush & ~bypass;
    assign fifo_count = count;
    assign res_valid  = trk_vld[MAC_LAT-1];
    assign res_op     = trk_op[MAC_LAT-1];

    // Select the packet that would issue this cycle (bypass or FIFO head)
    always_comb begin
        issue_instr = mem_instr[rd_ptr];
        issue_mplr  = mem_mplr[rd_ptr];
        issue_mcnd  = mem_mcnd[rd_ptr];
        if (bypass) begin
            issue_instr = in_instruction;
            issue_mplr  = in_multiplier;
            issue_mcnd  = in_multiplicand;
        end
    end

    // MAC operands: live packet when issuing, frozen last issue when stalled
    always_comb begin
        mac_instruction  = issue_instr;
        mac_multiplier   = issue_mplr;
        mac_multiplicand = issue_mcnd;
        if (mac_stall) begin
            mac_instruction  = last_instr;
            mac_multiplier   = last_mplr;
            mac_multiplicand = last_mcnd;
        end
    end

    // FIFO write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= in_instruction;
            mem_mplr[wr_ptr]  <= in_multiplier;
            mem_mcnd[wr_ptr]  <= in_multiplicand;
        end
    end

    // Pointers, occupancy, last-issued packet and latency tracker
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_instr <= '0;
            last_mplr  <= '0;
            last_mcnd  <= '0;
            for (int i = 0; i < MAC_LAT; i++) begin
                trk_vld[i] <= 1'b0;
                trk_op[i]  <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MAC_LAT; i++) begin
                trk_vld[i] <= 1'b0;
                trk_op[i]  <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
            if (issue) begin
                last_instr <= issue_instr;
                last_mplr  <= issue_mplr;
                last_mcnd  <= issue_mcnd;
                for (int i = MAC_LAT - 1; i > 0; i--) begin
                    trk_vld[i] <= trk_vld[i-1];
                    trk_op[i]  <= trk_op[i-1];
                end
                trk_vld[0] <= 1'b1;
                trk_op[0]  <= issue_instr;
            end
        end
    end

endmodule

// File: tb/tb_mac_issue_queue.sv
// Randomized bench for mac_issue_queue against a queue-based reference model.
module tb_mac_issue_queue;

    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int MAC_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        ext_hold;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_instruction;
    logic [15:0] in_multiplier;
    logic [15:0] in_multiplicand;
    logic [2:0]  mac_instruction;
    logic [15:0] mac_multiplier;
    logic [15:0] mac_multiplicand;
    logic        mac_stall;
    logic        res_valid;
    logic [2:0]  res_op;
    logic [ADDR_W:0] fifo_count;

    mac_issue_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush            (flush),
        .ext_hold         (ext_hold),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_instruction   (in_instruction),
        .in_multiplier    (in_multiplier),
        .in_multiplicand  (in_multiplicand),
        .mac_instruction  (mac_instruction),
        .mac_multiplier   (mac_multiplier),
        .mac_multiplicand (mac_multiplicand),
        .mac_stall        (mac_stall),
        .res_valid        (res_valid),
        .res_op           (res_op),
        .fifo_count       (fifo_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: packet = {op[34:32], multiplier[31:16], multiplicand[15:0]}
    logic [34:0] mq[$];      // queued packets, head at index 0
    logic [2:0]  hist[$];    // opcodes issued on the most recent advancing edges
    logic [34:0] last_pkt;   // last packet handed to the MAC
    logic [34:0] pkt;        // packet currently offered upstream
    bit          pend;       // upstream is holding an unaccepted packet

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        hist.delete();
        last_pkt = '0;
        pend     = 1'b0;
    endtask

    task automatic check_reset_state();
        check_val("rst_count", 32'(fifo_count), 32'd0);
        check_val("rst_ready", 32'(in_ready), 32'd1);
        check_val("rst_stall", 32'(mac_stall), 32'd1);
        check_val("rst_instr", 32'(mac_instruction), 32'd0);
        check_val("rst_mplr",  32'(mac_multiplier), 32'd0);
        check_val("rst_mcnd",  32'(mac_multiplicand), 32'd0);
        check_val("rst_resv",  32'(res_valid), 32'd0);
        check_val("rst_resop", 32'(res_op), 32'd0);
    endtask

    // One clock cycle: drive at negedge, check 1ns later, advance model at posedge
    task automatic step(input int pv, input int ph, input int pf);
        bit          byp;
        bit          e_stall;
        bit          e_rdy;
        bit          accept;
        logic [34:0] head;
        logic [34:0] e_mac;
        logic [31:0] rnd;
        @(negedge clk);
        if (pend) begin
            in_valid = 1'b1;
        end else begin
            in_valid = ($urandom_range(99) < pv);
            if (in_valid) begin
                rnd = $urandom;
                pkt = {3'($urandom_range(7)), rnd};
                pend = 1'b1;
            end
        end
        in_instruction  = pkt[34:32];
        in_multiplier   = pkt[31:16];
        in_multiplicand = pkt[15:0];
        ext_hold = ($urandom_range(99) < ph);
        flush    = ($urandom_range(99) < pf);
        #1;
`ifdef MAC_ISSUE_BYPASS_EN
        byp = (mq.size() == 0) && in_valid && !ext_hold && !flush;
`else
        byp = 1'b0;
`endif
        e_stall = ((mq.size() == 0) && !byp) || ext_hold || flush;
        e_rdy   = (mq.size() != DEPTH);
        head    = byp ? pkt : ((mq.size() != 0) ? mq[0] : 35'd0);
        e_mac   = e_stall ? last_pkt : head;
        check_val("stall", 32'(mac_stall), 32'(e_stall));
        check_val("ready", 32'(in_ready), 32'(e_rdy));
        check_val("count", 32'(fifo_count), 32'(mq.size()));
        check_val("instr", 32'(mac_instruction), 32'(e_mac[34:32]));
        check_val("mplr",  32'(mac_multiplier), 32'(e_mac[31:16]));
        check_val("mcnd",  32'(mac_multiplicand), 32'(e_mac[15:0]));
        check_val("res_valid", 32'(res_valid), 32'(hist.size() == MAC_LAT));
        if (hist.size() == MAC_LAT) begin
            check_val("res_op", 32'(res_op), 32'(hist[0]));
        end
        accept = in_valid && e_rdy;
        @(posedge clk);
        if (flush) begin
            mq.delete();
            hist.delete();
        end else begin
            if (!e_stall) begin
                last_pkt = head;
                hist.push_back(head[34:32]);
                if (hist.size() > MAC_LAT) void'(hist.pop_front());
                if (!byp) void'(mq.pop_front());
            end
            if (accept && !byp) mq.push_back(pkt);
        end
        if (accept) pend = 1'b0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        ext_hold = 1'b0;
        #1;
        check_reset_state();
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n         = 1'b0;
        flush           = 1'b0;
        ext_hold        = 1'b0;
        in_valid        = 1'b0;
        in_instruction  = '0;
        in_multiplier   = '0;
        in_multiplicand = '0;
        pkt             = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        reset_n = 1'b1;

        // Light mixed traffic
        repeat (300) step(50, 20, 2);
        // Fill under heavy hold, then drain with hold released
        repeat (200) step(90, 90, 0);
        repeat (40)  step(0, 0, 0);
        // Saturated input: steady push+pop with pointer wrap
        repeat (200) step(100, 10, 0);
        // Frequent flushes
        repeat (300) step(70, 40, 10);
        // Reset while queue is busy, then continue
        repeat (30)  step(90, 80, 0);
        async_reset();
        repeat (300) step(60, 30, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
